// File: rtl/led_seq_ctrl.sv
// Sequencer for the 8-LED board: scan position counter, tick prescaler and IDLE/RUN/HOLD FSM.
// Pattern requests are latched only at period boundaries so a sweep is never cut short.
module led_seq_ctrl #(
    parameter int PRESCALE = 4,
    parameter int PRE_W    = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic [1:0] mode,
    output logic [7:0] led,
    output logic [2:0] pos,
    output logic [1:0] cur_mode,
    output logic       busy,
    output logic       step,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_t             r_state;
    logic [PRE_W-1:0]   r_pre;
    logic [2:0]         r_pos;
    logic               r_dir;
    logic [1:0]         r_cur_mode;
    logic [7:0]         r_led;
    logic               r_busy;
    logic               r_step;
    logic               r_wrap;

    state_t             w_state_nx;
    logic [PRE_W-1:0]   w_pre_nx;
    logic [2:0]         w_pos_nx;
    logic               w_dir_nx;
    logic [1:0]         w_mode_nx;
    logic [7:0]         w_led_nx;
    logic               w_step_nx;
    logic               w_wrap_nx;
    logic               w_tick;
    logic [2:0]         w_adv_pos;
    logic               w_adv_dir;
    logic               w_terminal;

    function automatic logic [2:0] init_pos(input logic [1:0] md);
        return (md == 2'b01) ? 3'd0 : 3'd7;
    endfunction

    function automatic logic [7:0] led_pattern(input logic [1:0] md, input logic [2:0] p);
        logic [7:0] v;
        case (md)
            2'b11:   v = p[0] ? 8'hFF : 8'h00;
            default: v = 8'h01 << p;
        endcase
        return v;
    endfunction

    // Position the current pattern would move to on a tick, and whether that tick closes the period
    always_comb begin
        w_adv_pos  = r_pos;
        w_adv_dir  = 1'b0;
        w_terminal = 1'b0;
        case (r_cur_mode)
            2'b01: begin
                w_adv_pos  = r_pos + 3'd1;
                w_terminal = (r_pos == 3'd7);
            end
            2'b10: begin
                if (r_dir) begin
                    w_adv_pos  = r_pos + 3'd1;
                    w_adv_dir  = 1'b1;
                    w_terminal = (r_pos == 3'd6);
                end else if (r_pos == 3'd0) begin
                    w_adv_pos  = 3'd1;
                    w_adv_dir  = 1'b1;
                end else begin
                    w_adv_pos  = r_pos - 3'd1;
                end
            end
            default: begin
                w_adv_pos  = r_pos - 3'd1;
                w_terminal = (r_pos == 3'd0);
            end
        endcase
    end

    // Next-state logic; the LED value is derived from the next-state position and mode
    always_comb begin
        w_state_nx = r_state;
        w_pre_nx   = r_pre;
        w_pos_nx   = r_pos;
        w_dir_nx   = r_dir;
        w_mode_nx  = r_cur_mode;
        w_step_nx  = 1'b0;
        w_wrap_nx  = 1'b0;
        w_tick     = (r_state == ST_RUN) && (r_pre == PRE_LAST);

        if (stop) begin
            w_state_nx = ST_IDLE;
            w_pre_nx   = '0;
            w_pos_nx   = 3'd7;
            w_dir_nx   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nx = ST_RUN;
                        w_mode_nx  = mode;
                        w_pos_nx   = init_pos(mode);
                        w_dir_nx   = 1'b0;
                        w_pre_nx   = '0;
                    end else begin
                        w_pre_nx   = '0;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with hold still completes; freezing starts afterwards
                    w_state_nx = hold ? ST_HOLD : ST_RUN;
                    if (w_tick) begin
                        w_pre_nx  = '0;
                        w_step_nx = 1'b1;
                        if (w_terminal) begin
                            w_wrap_nx = 1'b1;
                            w_mode_nx = mode;
                            w_pos_nx  = init_pos(mode);
                            w_dir_nx  = 1'b0;
                        end else begin
                            w_pos_nx  = w_adv_pos;
                            w_dir_nx  = w_adv_dir;
                        end
                    end else begin
                        w_pre_nx = r_pre + {{(PRE_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HOLD: begin
                    w_state_nx = hold ? ST_HOLD : ST_RUN;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_pre_nx   = '0;
                    w_pos_nx   = 3'd7;
                    w_dir_nx   = 1'b0;
                end
            endcase
        end

        w_led_nx = (w_state_nx == ST_IDLE) ? 8'h00 : led_pattern(w_mode_nx, w_pos_nx);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pre      <= '0;
            r_pos      <= 3'd7;
            r_dir      <= 1'b0;
            r_cur_mode <= 2'b00;
            r_led      <= 8'h00;
            r_busy     <= 1'b0;
            r_step     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pre      <= w_pre_nx;
            r_pos      <= w_pos_nx;
            r_dir      <= w_dir_nx;
            r_cur_mode <= w_mode_nx;
            r_led      <= w_led_nx;
            r_busy     <= (w_state_nx != ST_IDLE);
            r_step     <= w_step_nx;
            r_wrap     <= w_wrap_nx;
        end
    end

    assign led      = r_led;
    assign pos      = r_pos;
    assign cur_mode = r_cur_mode;
    assign busy     = r_busy;
    assign step     = r_step;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed and randomized bench for led_seq_ctrl against a period-index reference model.
module tb_led_seq_ctrl;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] led;
    logic [2:0] pos;
    logic [1:0] cur_mode;
    logic       busy;
    logic       step;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: where we are inside the pattern period, not how the RTL counts
    bit         m_active;
    bit         m_held;
    int         m_cnt;
    int         m_k;
    logic [1:0] m_mode;
    logic       m_step;
    logic       m_wrap;

    led_seq_ctrl #(.PRESCALE(P), .PRE_W(25)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold), .mode(mode),
        .led(led), .pos(pos), .cur_mode(cur_mode), .busy(busy), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic int period(input logic [1:0] md);
        return (md == 2'b10) ? 14 : 8;
    endfunction

    function automatic logic [2:0] seq_pos(input logic [1:0] md, input int k);
        case (md)
            2'b01:   return 3'(k);
            2'b10:   return (k <= 7) ? 3'(7 - k) : 3'(k - 7);
            default: return 3'(7 - k);
        endcase
    endfunction

    function automatic logic [2:0] m_pos();
        return m_active ? seq_pos(m_mode, m_k) : 3'd7;
    endfunction

    function automatic logic [7:0] m_led();
        logic [2:0] p;
        if (!m_active) return 8'h00;
        p = seq_pos(m_mode, m_k);
        if (m_mode == 2'b11) return p[0] ? 8'hFF : 8'h00;
        return 8'h01 << p;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_held = 1'b0; m_cnt = 0; m_k = 0;
        m_mode = 2'b00; m_step = 1'b0; m_wrap = 1'b0;
    endtask

    task automatic model_step();
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (stop) begin
            m_active = 1'b0; m_held = 1'b0; m_cnt = 0; m_k = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_held = 1'b0; m_mode = mode; m_k = 0; m_cnt = 0;
            end
        end else if (m_held) begin
            m_held = hold;
        end else begin
            m_cnt++;
            if (m_cnt == P) begin
                m_cnt = 0;
                m_step = 1'b1;
                m_k++;
                if (m_k == period(m_mode)) begin
                    m_k = 0;
                    m_wrap = 1'b1;
                    m_mode = mode;
                end
            end
            m_held = hold;
        end
    endtask

    task automatic check(input string tag);
        logic [14:0] obs, exp;
        obs = {led, pos, cur_mode, busy, step, wrap};
        exp = {m_led(), m_pos(), m_mode, m_active, m_step, m_wrap};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (led,pos,cur_mode,busy,step,wrap)", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk(input string tag);
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
        check(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick_clk(tag);
    endtask

    task automatic do_stop();
        stop = 1'b1; tick_clk("stop"); stop = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] md);
        mode = md; start = 1'b1; tick_clk("start"); start = 1'b0;
    endtask

    initial begin
        int cnt;
        int steps;
        bit seen;
        model_reset();
        #23;
        check_val("reset_vals", {1'b0, led, pos, cur_mode, busy, step, wrap},
                  {1'b0, 8'h00, 3'd7, 2'b00, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        run("idle", 2);

        // 1: down-scan, wrap 32 clocks after start, 8 steps per period
        do_start(2'b00);
        check_val("t1_led_start", {8'h00, led}, 16'h0080);
        cnt = 0; steps = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick_clk("t1");
            cnt++;
            if (step) steps++;
            if (wrap) seen = 1'b1;
        end
        check_val("t1_wrap_latency", 16'(cnt), 16'd32);
        check_val("t1_steps_per_period", 16'(steps), 16'd8);
        check_val("t1_pos_after_wrap", {13'd0, pos}, 16'd7);
        run("t1", 8);

        // 2: up-scan
        do_stop();
        do_start(2'b01);
        check_val("t2_led_start", {8'h00, led}, 16'h0001);
        run("t2", 40);

        // 3: ping-pong over more than one period
        do_stop();
        do_start(2'b10);
        run("t3", 14 * P + 8);

        // 4: mode request mid-sweep takes effect only at the boundary
        do_stop();
        do_start(2'b00);
        run("t4", 4 * P);
        check_val("t4_pos3", {13'd0, pos}, 16'd3);
        mode = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick_clk("t4");
            if (!wrap) check_val("t4_mode_held", {14'd0, cur_mode}, 16'd0);
            if (wrap) seen = 1'b1;
        end
        check_val("t4_wrap_seen", {15'd0, seen}, 16'd1);
        check_val("t4_at_wrap", {3'd0, led, pos, cur_mode}, {3'd0, 8'h01, 3'd0, 2'b01});
        run("t4", 8);

        // 5: blink and hold
        do_stop();
        do_start(2'b11);
        check_val("t5_led_start", {8'h00, led}, 16'h00FF);
        run("t5", 3 * P + 1);
        check_val("t5_pos4", {13'd0, pos}, 16'd4);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_clk("t5_hold");
            check_val("t5_frozen", {4'd0, led, pos, busy}, {4'd0, 8'h00, 3'd4, 1'b1});
        end
        hold = 1'b0;
        run("t5_resume", 20);

        // 6a: stop on a tick edge
        seen = 1'b0;
        for (int i = 0; i < 2 * P && !seen; i++) begin
            if (m_active && !m_held && m_cnt == P - 1) seen = 1'b1;
            else tick_clk("t6_seek");
        end
        check_val("t6_tick_found", {15'd0, seen}, 16'd1);
        do_stop();
        check_val("t6_stop_tick", {4'd0, led, pos, busy, step, wrap},
                  {4'd0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0});
        // 6b: start and stop together in IDLE
        mode = 2'b01; start = 1'b1; stop = 1'b1;
        tick_clk("t6_both");
        start = 1'b0; stop = 1'b0;
        check_val("t6_both_idle", {4'd0, led, pos, busy, step, wrap},
                  {4'd0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0});
        // 6c: asynchronous reset mid-run
        do_start(2'b10);
        run("t6_run", 10);
        reset = 1'b1;
        #2;
        check_val("t6_async_reset", {1'b0, led, pos, cur_mode, busy, step, wrap},
                  {1'b0, 8'h00, 3'd7, 2'b00, 1'b0, 1'b0, 1'b0});
        model_reset();
        tick_clk("t6_in_reset");
        #3;
        reset = 1'b0;
        run("t6_post", 2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            tick_clk("rand");
        end
        start = 1'b0; stop = 1'b0; hold = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer for the 8-LED light board.
- Owns a 3-bit scan position counter, a tick prescaler and a run/hold/idle FSM.
- Drives one-hot or blink patterns onto the LED bank.
- Pattern changes are taken only at sequence boundaries, so the display never glitches mid-sweep.

Parameters:
- PRESCALE, 4, clocks per display step; the board build overrides this to 25000000. Legal range is 2 or more.
- PRE_W, 25, prescaler counter width; must satisfy 2^PRE_W >= PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; IDLE->RUN.
- stop  in  1  one-cycle pulse; any state->IDLE. Has priority over start.
- hold  in  1  level; freezes the sequence while in RUN.
- mode  in  2  requested pattern: 00 down-scan, 01 up-scan, 10 ping-pong, 11 blink.
- led  out  8  LED drive, active-high.
- pos  out  3  current scan position.
- cur_mode  out  2  pattern currently in effect.
- busy  out  1  high in RUN or HOLD.
- step  out  1  one-cycle pulse on every position advance.
- wrap  out  1  one-cycle pulse on the advance that completes a full pattern period.

Behaviour:
- Reset values: state=IDLE, pre=0, pos=7, dir=down, cur_mode=00, led=8'h00, busy=0, step=0, wrap=0.
- All outputs are registered.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: on start (and no stop), go to RUN. In the same edge: cur_mode<=mode, pos<=init(mode), dir<=down, pre<=0.
  - init(mode) = 0 for mode 01; init(mode) = 7 for all other modes.
  - RUN: if hold=1, go to HOLD. HOLD: if hold=0, go to RUN.
  - stop in any state: go to IDLE next edge, with pos=7, led=0, pre=0, dir=down. cur_mode keeps its last value.
  - start while in RUN or HOLD is ignored.
- Prescaler:
  - Counts only in RUN: pre=0..PRESCALE-1. tick is asserted when pre==PRESCALE-1, and pre then returns to 0.
  - Frozen in HOLD, held at 0 in IDLE.
  - The first step after start occurs PRESCALE clocks after the start edge.
- Position update on tick:
  - 00 and 11: pos-1, wrapping 0->7.
  - 01: pos+1, wrapping 7->0.
  - 10: pos-1 while dir=down. When pos==0, next pos=1 and dir<=up. While dir=up, pos+1. The end positions 0 and 7 are each shown for only one step, giving a period of 14 steps.
- Terminal step, which drives wrap:
  - 00/11: pos==0.
  - 01: pos==7.
  - 10: dir=up and pos==6.
  - On a terminal tick: wrap=1, cur_mode<=mode (resampled), pos<=init(new mode), dir<=down.
  - A mode change at any other time has no effect until the next terminal tick.
- step and wrap are registered alongside the pos update and are high for exactly 1 clock.
- led, registered from the next-state values:
  - IDLE: 8'h00.
  - Modes 00/01/10: 1<<pos.
  - Mode 11: 8'hFF if pos[0]==1, else 8'h00.
- busy=1 in RUN/HOLD. Updates on the same edge as the state change.
- Simultaneous events:
  - stop+start: stop wins.
  - stop+tick: stop wins; no step or wrap pulse.
  - hold asserted on a tick edge: that tick completes, and freezing begins on the next cycle.
- Reset mid-operation: immediate return to the reset values, asynchronous to clk.

Test Plan (PRESCALE=4):
1. Reset, then start with mode=00. Expected: pos=7 and led=8'h80 on the next edge; pos steps 6,5,...,0,7 every 4 clocks. wrap fires on the 0->7 step, 32 clocks after start. step fires 8 times per period.
2. mode=01 start. Expected: led sequence 01,02,...,80,01; wrap on the 7->0 step.
3. mode=10. Expected: pos sequence 7,6,5,4,3,2,1,0,1,...,6,7; wrap only on the 6->7 step (every 14 steps); dir flips at 0.
4. Running 00 at pos=3, switch mode to 01. Expected: cur_mode stays 00 until the 0->7 boundary. At wrap, pos=0, cur_mode=01, led=8'h01.
5. mode=11. Expected: led alternates FF,00 each step starting FF. Hold high for 10 clocks at pos=4: led/pos frozen, no step, busy=1; release resumes with the remaining prescale count.
6. Assert stop coincident with a tick, start+stop together in IDLE, and reset mid-RUN. Expected in all cases: IDLE, led=00, pos=7, busy=0, no step/wrap pulse.
